// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with runtime-programmable ratios and a lock sequencer.
// Define CLKGEN_LOCK_DELAY_EN to hold WAIT for LOCK_CYCLES cycles; otherwise WAIT lasts 1 cycle.
module clk_div_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned DIV_INIT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_busy,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ce_out,
  output logic              locked
);

  localparam logic [1:0] StRst    = 2'd0;
  localparam logic [1:0] StWait   = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] wrap_at [NUM_CH];
  logic [NUM_CH-1:0] clk_q, ce_q;
  logic             locked_q;
  logic             accept;
  logic             lock_done;

  assign accept = cfg_we & (state_q == StLocked) & (32'(cfg_ch) < NUM_CH);

`ifdef CLKGEN_LOCK_DELAY_EN
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [LockW-1:0] lock_cnt_q;

  assign lock_done = (lock_cnt_q == LockW'(LOCK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
    end else if (state_q == StWait) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end else begin
      lock_cnt_q <= '0;
    end
  end
`else
  logic unused_lock_cycles;

  assign unused_lock_cycles = ^LOCK_CYCLES;
  assign lock_done          = 1'b1;
`endif

  // An accepted write re-arms through StRst, so a relock takes one cycle more than
  // the post-reset lock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst:    state_d = StWait;
      StWait:   if (lock_done) state_d = StLocked;
      StLocked: if (accept) state_d = StRst;
      default:  state_d = StRst;
    endcase
  end

  // A ratio of 0 wraps like a ratio of 1.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap_at[i] = (div_q[i] == '0) ? '0 : div_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRst;
      locked_q <= 1'b0;
      clk_q    <= '0;
      ce_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(DIV_INIT);
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == StLocked);
      for (int i = 0; i < NUM_CH; i++) begin
        if (state_q == StLocked && !accept) begin
          if (cnt_q[i] == wrap_at[i]) begin
            cnt_q[i] <= '0;
            ce_q[i]  <= 1'b1;
            clk_q[i] <= ~clk_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
            ce_q[i]  <= 1'b0;
          end
        end else begin
          cnt_q[i] <= '0;
          ce_q[i]  <= 1'b0;
          clk_q[i] <= 1'b0;
        end
        if (accept && cfg_ch == 2'(i)) begin
          div_q[i] <= cfg_div;
        end
      end
    end
  end

  assign clk_out  = clk_q;
  assign ce_out   = ce_q;
  assign locked   = locked_q;
  assign cfg_busy = ~locked_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: expected outputs are derived from lock-edge arithmetic.
module tb_clk_div_gen;

`ifdef CLKGEN_LOCK_DELAY_EN
  localparam int LD = 16;
`else
  localparam int LD = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_busy;
  logic [2:0] clk_out;
  logic [2:0] ce_out;
  logic       locked;

  clk_div_gen #(
    .NUM_CH     (3),
    .DIV_W      (8),
    .LOCK_CYCLES(16),
    .DIV_INIT   (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .cfg_busy(cfg_busy),
    .clk_out (clk_out),
    .ce_out  (ce_out),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int lock_edge = LD;
  int divm [3];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  // Expected {busy, locked, ce[2:0], clk[2:0]} just after edge n.
  function automatic logic [7:0] expect_at(input int n);
    logic [2:0] ce;
    logic [2:0] ck;
    int k;
    int d;
    ce = '0;
    ck = '0;
    k  = n - lock_edge;
    for (int i = 0; i < 3; i++) begin
      d = (divm[i] == 0) ? 1 : divm[i];
      if (k > 0) begin
        ce[i] = ((k % d) == 0);
        ck[i] = (((k / d) % 2) == 1);
      end
    end
    return {(n < lock_edge), (n >= lock_edge), ce, ck};
  endfunction

  task automatic step();
    int ne;
    logic [7:0] got;
    logic [7:0] want;
    ne = edge_cnt;
    if (cfg_we && (ne - 1 >= lock_edge) && cfg_ch < 2'd3) begin
      divm[cfg_ch] = int'(cfg_div);
      lock_edge    = ne + 1 + LD;
    end
    exp_q.push_back(expect_at(ne));
    @(posedge clk);
    edge_cnt++;
    @(negedge clk);
    got = {cfg_busy, locked, ce_out, clk_out};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check("outputs", 32'(got), 32'(want));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({cfg_busy, locked, ce_out, clk_out}), 32'h80);
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    for (int i = 0; i < 3; i++) divm[i] = 1;
    #1;
    check_reset_outputs("reset_values");
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_held");
    rst_n     = 1'b1;
    edge_cnt  = 0;
    lock_edge = LD;
    run(LD + 10);

    // Ratio 4 on channel 1.
    write(2'd1, 8'd4);
    run(LD + 20);

    // Out-of-range channel: no relock.
    write(2'd3, 8'd9);
    run(6);

    // Accepted write followed immediately by a write while busy.
    write(2'd0, 8'd2);
    write(2'd2, 8'd7);
    run(LD + 12);

    // Ratio 0 behaves as 1; write lands while channel 1 wraps on some cycle.
    write(2'd0, 8'd0);
    run(LD + 10);

    write(2'd2, 8'd5);
    run(LD + 13);

    // Asynchronous reset mid-LOCKED.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("reset_mid_run_held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) divm[i] = 1;
    lock_edge = edge_cnt + LD;
    run(LD + 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
